// File: rtl/nov_sram_pkg.sv
// Shared types and constants for the SRAM stream controller slice.
// The read latency here must match the sram_sp_sky130 wrapper it drives.
package nov_sram_pkg;

  localparam int RD_LAT       = 2;
  localparam int IDATA_WIDTH  = 8;
  localparam int MAC_MULT_NUM = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } sram_ctrl_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// First-word-fall-through skid FIFO that absorbs SRAM read data.
// The head word is visible on rdata whenever empty is low.
module sram_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_BIT = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic [CNT_BIT-1:0] count,
  output logic               empty,
  output logic               full
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BIT-1:0] count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_BIT-1:0] ptr_inc(input logic [PTR_BIT-1:0] p);
    return (p == PTR_BIT'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_BIT'(DEPTH));

endmodule

// File: rtl/sram_stream_ctrl.sv
// Command-driven block mover between one single-port SRAM and valid/ready streams.
// Reads are credit-limited so the skid FIFO can never overflow under backpressure.
module sram_stream_ctrl
  import nov_sram_pkg::*;
#(
  parameter int DATA_BIT   = IDATA_WIDTH * MAC_MULT_NUM,
  parameter int DEPTH      = 128,
  parameter int ADDR_BIT   = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_BIT-1:0] cmd_addr,
  input  logic [ADDR_BIT:0]   cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_BIT-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic                mem_wen,
  output logic                mem_ren,
  output logic [DATA_BIT-1:0] mem_wdata,
  input  logic [DATA_BIT-1:0] mem_rdata
);

  localparam int CNT_BIT = $clog2(FIFO_DEPTH + 1);

  sram_ctrl_state_t    state_q, state_d;
  logic [ADDR_BIT-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_BIT:0]   remain_q, remain_d;
  logic [RD_LAT-1:0]   inflight_q, inflight_d;

  logic               wr_fire;
  logic               rd_issue;
  logic               credit_ok;
  logic [CNT_BIT:0]   inflight_cnt;
  logic [CNT_BIT-1:0] fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;

  function automatic logic [ADDR_BIT-1:0] addr_inc(input logic [ADDR_BIT-1:0] a);
    return (a == ADDR_BIT'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Credits count both buffered words and reads still in the SRAM pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + (CNT_BIT + 1)'(inflight_q[i]);
    end
  end

  assign credit_ok = !fifo_full &&
                     (((CNT_BIT + 1)'(fifo_count) + inflight_cnt) < (CNT_BIT + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          remain_d   = cmd_len;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          cur_addr_d = addr_inc(cur_addr_q);
          remain_d   = remain_q - 1'b1;
          if (remain_q == (ADDR_BIT + 1)'(1)) state_d = DONE;
        end
      end
      READ: begin
        if (rd_issue) begin
          cur_addr_d = addr_inc(cur_addr_q);
          remain_d   = remain_q - 1'b1;
          if (remain_q == (ADDR_BIT + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    wr_ready  = (state_q == WRITE);
    wr_fire   = (state_q == WRITE) && wr_valid;
    rd_issue  = (state_q == READ) && credit_ok;
    mem_wen   = wr_fire;
    mem_ren   = rd_issue;
    mem_addr  = cur_addr_q;
    mem_wdata = wr_fire ? wr_data : '0;
  end

  assign inflight_d[0] = rd_issue;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_inflight
      assign inflight_d[gi] = inflight_q[gi-1];
    end
  endgenerate

  assign fifo_push = inflight_q[RD_LAT-1];
  assign fifo_pop  = rd_valid && rd_ready;
  assign rd_valid  = !fifo_empty;

  sram_rd_fifo #(
    .WIDTH (DATA_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (rd_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl with a 2-cycle-latency SRAM model.
module tb_sram_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [6:0]  mem_addr;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // SRAM model: unwritten word i holds 0xC0DE0000+i; read data lands two cycles after ren.
  logic [31:0] mem [128];
  logic [31:0] rd_stage;
  initial for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + i;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) rd_stage <= mem[mem_addr];
    mem_rdata <= rd_stage;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int ren_q[$], wen_q[$], pop_q[$], done_q[$], acc_q[$];
  int first_rv = -1;
  int busy_cnt = 0;
  int rv_cnt = 0;
  int fifo_max = 0;
  int viol_both = 0, viol_full = 0, viol_empty = 0;
  bit bp_mode = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ren) ren_q.push_back(cyc);
      if (mem_wen) wen_q.push_back(int'(mem_addr));
      if (rd_valid && rd_ready) pop_q.push_back(int'(rd_data));
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (done) done_q.push_back(cyc);
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (rd_valid) rv_cnt++;
    end
    if (mem_wen && mem_ren) viol_both++;
    if (dut.u_rd_fifo.push && dut.u_rd_fifo.full) viol_full++;
    if (dut.u_rd_fifo.pop && dut.u_rd_fifo.empty) viol_empty++;
    if (int'(dut.u_rd_fifo.count) > fifo_max) fifo_max = int'(dut.u_rd_fifo.count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    ren_q.delete(); wen_q.delete(); pop_q.delete(); done_q.delete(); acc_q.delete();
    first_rv = -1; busy_cnt = 0; rv_cnt = 0;
  endtask

  task automatic send_cmd(input logic w, input int addr, input int len, output int acc);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = 7'(addr); cmd_len = 8'(len);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) begin acc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (acc < 0) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      wr_valid = 1'b1;
      wr_data  = base + i;
      for (int j = 0; j < 50; j++) begin
        @(negedge clk); #1;
        if (wr_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) check("wr_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done) begin dcyc = cyc; break; end
      @(posedge clk); #1;
      if (bp_mode) rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
    @(posedge clk); #1;
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int acc, d, d1, r0, span;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_en", {mem_wen, mem_ren}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write 0xA0..0xA3 at 5, then read it back.
    clear_logs();
    send_cmd(1'b1, 5, 4, acc);
    write_words(32'hA0, 4);
    wait_done(d);
    check("wr_done_latency", d - acc, 5);
    for (int i = 0; i < 4; i++) check($sformatf("wr_addr%0d", i), qat(wen_q, i), 5 + i);
    check("wr_done_count", done_q.size(), 1);
    $display("txn write addr=5 len=4 accept=%0d done=%0d", acc, d);

    clear_logs();
    rd_ready = 1'b1;
    send_cmd(1'b0, 5, 4, acc);
    wait_done(d);
    r0 = qat(ren_q, 0);
    check("rd_issue_latency", r0 - acc, 1);
    check("rd_first_valid", first_rv - r0, 3);
    check("rd_pop_count", pop_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rd_data%0d", i), qat(pop_q, i), 32'hA0 + i);
    check("rd_done_count", done_q.size(), 1);
    $display("txn read addr=5 len=4 accept=%0d done=%0d", acc, d);

    // Read 16 unwritten words with rd_ready pattern 1,0,0,1.
    clear_logs();
    fifo_max = 0;
    bp_mode = 1'b1;
    send_cmd(1'b0, 20, 16, acc);
    wait_done(d);
    bp_mode = 1'b0;
    rd_ready = 1'b1;
    span = qat(ren_q, 15) - qat(ren_q, 0) + 1;
    check("bp_ren_count", ren_q.size(), 16);
    check("bp_ren_stalled", span > 16, 1);
    check("bp_fifo_max_le4", fifo_max <= 4, 1);
    check("bp_pop_count", pop_q.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("bp_data%0d", i), qat(pop_q, i), 32'hC0DE_0014 + i);
    $display("txn read_bp addr=20 len=16 accept=%0d done=%0d ren_span=%0d", acc, d, span);

    // Address wrap at the top of the array.
    clear_logs();
    send_cmd(1'b1, 127, 3, acc);
    write_words(32'hB0, 3);
    wait_done(d);
    check("wrap_addr0", qat(wen_q, 0), 127);
    check("wrap_addr1", qat(wen_q, 1), 0);
    check("wrap_addr2", qat(wen_q, 2), 1);
    clear_logs();
    send_cmd(1'b0, 127, 3, acc);
    wait_done(d);
    check("wrap_pop_count", pop_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("wrap_data%0d", i), qat(pop_q, i), 32'hB0 + i);
    $display("txn wrap write/read addr=127 len=3 done=%0d", d);

    // Zero-length command.
    clear_logs();
    send_cmd(1'b1, 10, 0, acc);
    wait_done(d);
    check("zero_done_latency", d - acc, 1);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_mem_access", wen_q.size() + ren_q.size(), 0);
    $display("txn zero_len accept=%0d done=%0d", acc, d);

    // Second command offered while a read is running.
    clear_logs();
    send_cmd(1'b0, 5, 8, acc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd0; cmd_len = 8'd1;
    @(negedge clk); #1;
    check("lockout_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    wait_done(d1);
    @(negedge clk); #1;
    check("lockout_ready_after", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(d);
    check("lockout_accepts", acc_q.size(), 2);
    check("lockout_accept_cycle", qat(acc_q, 1) - d1, 1);
    check("lockout_pop_count", pop_q.size(), 9);
    for (int i = 0; i < 4; i++) check($sformatf("lockout_data%0d", i), qat(pop_q, i), 32'hA0 + i);
    for (int i = 4; i < 8; i++) check($sformatf("lockout_data%0d", i), qat(pop_q, i), 32'hC0DE_0005 + i);
    check("lockout_data8", qat(pop_q, 8), 32'hB1);
    $display("txn lockout first_done=%0d second_done=%0d", d1, d);

    // Reset one cycle after the third mem_ren of an 8-word read.
    clear_logs();
    rd_ready = 1'b0;
    send_cmd(1'b0, 40, 8, acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (ren_q.size() >= 3) break;
      @(posedge clk); #1;
    end
    check("rst_mid_ren3_seen", ren_q.size() >= 3, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_busy", busy, 0);
    rv_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_late_data", rv_cnt, 0);
    clear_logs();
    rd_ready = 1'b1;
    send_cmd(1'b0, 5, 2, acc);
    wait_done(d);
    check("rst_mid_fresh_count", pop_q.size(), 2);
    check("rst_mid_fresh_data0", qat(pop_q, 0), 32'hA0);
    check("rst_mid_fresh_data1", qat(pop_q, 1), 32'hA1);
    $display("txn reset_mid_read then read addr=5 len=2 done=%0d", d);

    check("never_wen_and_ren", viol_both, 0);
    check("never_push_on_full", viol_full, 0);
    check("never_pop_on_empty", viol_empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
